// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection / operand forwarding unit.
package hazard_pkg;

  // Widest register address the in-flight table can hold; narrower addresses are zero-extended.
  localparam int RD_MAX_W = 8;

  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                wen;
    logic                is_load;
  } inflight_entry_t;

  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_src_match.sv
// Per-source priority matcher: finds the youngest in-flight writer of rs and
// reports whether its result can already be forwarded.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]             rs,
  input  logic                              used,
  input  inflight_entry_t [FWD_DEPTH-1:0]   slots,
  output logic                              hit,
  output logic                              ready,
  output logic [SEL_W-1:0]                  idx
);

  localparam logic [SEL_W-1:0] LOAD_LAT_SEL = SEL_W'(LOAD_LAT);

  logic hit_load;

  // Scan oldest to youngest so the last hit written is the smallest slot index.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    idx      = '0;
    if (used && (rs != '0)) begin
      for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
        if (slots[i].valid && slots[i].wen && (slots[i].rd == RD_MAX_W'(rs))) begin
          hit      = 1'b1;
          hit_load = slots[i].is_load;
          idx      = SEL_W'(i);
        end
      end
    end
  end

  assign ready = !hit_load || (idx >= LOAD_LAT_SEL);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding beside decode: tracks post-decode writers
// and forwards or stalls per source. Optional counters under HAZARD_PERF_EN.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = sel_width(FWD_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]       id_rf_data,
  input  logic [REG_ADDR_W-1:0]         id_rd_addr,
  input  logic                          id_rd_wen,
  input  logic                          id_is_load,
  input  logic [FWD_DEPTH*XLEN-1:0]     stage_data,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]       fwd_data,
  output logic [FWD_DEPTH-1:0]          inflight_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_fwd_cnt
`endif
);

  inflight_entry_t [FWD_DEPTH-1:0] slots;
  inflight_entry_t                 new_entry;
  logic [NUM_SRC-1:0]              hazard;
  logic                            push;

  always_comb begin
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.rd      = RD_MAX_W'(id_rd_addr);
    new_entry.wen     = id_rd_wen && (id_rd_addr != '0);
    new_entry.is_load = id_is_load;
  end

  assign stall = id_valid && !flush && (|hazard);
  assign push  = id_valid && !flush && !stall;

  // Flush only blocks the push; older entries keep draining toward WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots <= '0;
    end else begin
      for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
        slots[i] <= slots[i-1];
      end
      slots[0] <= push ? new_entry : '0;
    end
  end

  always_comb begin
    inflight_valid = '0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      inflight_valid[i] = slots[i].valid;
    end
  end

  logic [NUM_SRC-1:0] fwd_hit;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic             hit;
    logic             ready;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  data;

    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .SEL_W      (SEL_W)
    ) u_match (
      .rs    (id_rs_addr[s*REG_ADDR_W +: REG_ADDR_W]),
      .used  (id_rs_used[s]),
      .slots (slots),
      .hit   (hit),
      .ready (ready),
      .idx   (idx)
    );

    assign hazard[s]  = hit && !ready;
    assign fwd_hit[s] = hit && ready;

    // A not-yet-ready producer leaves the RF value selected; stall keeps it from being consumed.
    always_comb begin
      sel  = SEL_W'(FWD_SEL_RF);
      data = id_rf_data[s*XLEN +: XLEN];
      if (hit && ready) begin
        sel = idx + SEL_W'(1);
        for (int i = 0; i < FWD_DEPTH; i++) begin
          if (idx == SEL_W'(i)) data = stage_data[i*XLEN +: XLEN];
        end
      end
    end

    assign fwd_sel[s*SEL_W +: SEL_W] = sel;
    assign fwd_data[s*XLEN +: XLEN]  = data;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] fwd_inc;
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_inc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      fwd_inc = fwd_inc + {31'b0, fwd_hit[s]};
    end
    fwd_sum = {1'b0, perf_fwd_cnt} + {1'b0, fwd_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (id_valid && !stall) perf_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
    end
  end
`else
  logic unused_fwd_hit;
  assign unused_fwd_hit = |fwd_hit;
`endif

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised hazard-detection and operand-forwarding unit for the in-order RISC-V pipeline; sits beside the decode stage.
- Keeps a registered in-flight table of destination writes, one slot per post-decode stage.
- Per source operand, selects the youngest matching producer, or the register-file value.
- Generates multi-cycle load-use stalls and supports flush; generalises the fixed 2-operand, fixed-stage stall/forward mux to N operands, D stages and configurable load latency.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands checked per instruction (1..3).
- FWD_DEPTH, 3, post-decode stages tracked (slot 0 = EX, 1 = MEM, 2 = WB).
- LOAD_LAT, 1, a load result is forwardable from slot index >= LOAD_LAT (1..FWD_DEPTH-1).
- SEL_W, $clog2(FWD_DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- id_valid  in  1  decode holds a valid instruction.
- id_rs_addr  in  NUM_SRC*REG_ADDR_W  source register addresses.
- id_rs_used  in  NUM_SRC  source actually read.
- id_rf_data  in  NUM_SRC*XLEN  register-file read data.
- id_rd_addr  in  REG_ADDR_W  destination register.
- id_rd_wen  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- stage_data  in  FWD_DEPTH*XLEN  result currently available in slot i (EX ALU out, MEM dm data/bypass, WB data).
- flush  in  1  kill the decode instruction (branch/jump taken).
- stall  out  1  hold fetch/decode registers; a bubble enters EX.
- fwd_sel  out  NUM_SRC*SEL_W  0 = RF, k = slot k-1.
- fwd_data  out  NUM_SRC*XLEN  selected operand.
- inflight_valid  out  FWD_DEPTH  slot-occupied debug view.

Behaviour:
- Table: FWD_DEPTH registered entries {valid, rd, wen, is_load}. Each posedge, slot[i] <= slot[i-1] and the oldest slot retires.
- Slot 0 load rule: slot[0] <= {1, id_rd_addr, id_rd_wen && id_rd_addr != 0, id_is_load} iff id_valid && !stall && !flush; otherwise slot 0 is loaded empty (bubble).
- Match for source s: only when id_rs_used[s] and rs != 0. Search for the smallest i with slot[i].valid && wen && rd == rs. The youngest match wins; older matches are ignored.
- Ready rule: a slot is ready iff !is_load || i >= LOAD_LAT.
- Matched and ready: fwd_sel = i+1, fwd_data = stage_data[i].
- No match: fwd_sel = 0, fwd_data = id_rf_data[s]. RF is write-first, so retired writes need no forwarding.
- Matched but not ready: hazard for that source.
- stall = id_valid && !flush && OR(hazard). Purely combinational from the table and decode inputs.
- Load in EX with LOAD_LAT = L stalls a dependent instruction L-i cycles, with bubbles inserted each cycle. Decode is re-evaluated every cycle; no stall history is kept.
- flush and stall together: flush wins, stall = 0, no push. Existing slots are not cleared; older instructions complete.
- Reset: all slots invalid, inflight_valid = 0, so stall = 0 and fwd_sel = 0.
- Reset mid-stall clears the table at that edge; stall drops the following cycle.
- fwd_data and fwd_sel are combinational; zero added latency.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_fwd_cnt[31:0].
  - perf_stall_cnt increments on each cycle stall = 1.
  - perf_fwd_cnt increments by the number of sources with fwd_sel != 0 while id_valid && !stall.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: the ports and counters are absent.

Decomposition:
- Package hazard_pkg holds:
  - the inflight_entry_t struct;
  - the FWD_SEL_RF = 0 constant;
  - a sel-width helper function.
- Sub-module hazard_src_match: per-source priority matcher producing hit, ready and index. Instantiated NUM_SRC times via generate.

Test Plan:
- Back-to-back ALU ops `add x5` then `sub x6,x5,x1`, stage_data[0] = 0x1234 -> fwd_sel[0] = 1, fwd_data[0] = 0x1234, stall = 0.
- `lw x7` then use of x7, LOAD_LAT = 1 -> stall = 1 for exactly one cycle; next cycle fwd_sel = 2 with stage_data[1]. Repeat with LOAD_LAT = 2 -> two stall cycles, then fwd_sel = 3.
- Two in-flight writers to x9 (slot 0 = 0xA, slot 2 = 0xB) -> fwd_data = 0xA, fwd_sel = 1.
- Source x0 with an in-flight writer to x0 -> fwd_sel = 0, fwd_data = id_rf_data, no stall.
- Load-use hazard with flush asserted the same cycle -> stall = 0, slot 0 empty on the next cycle, inflight_valid[0] = 0.
- rst asserted during a load stall -> table cleared, stall = 0 next cycle. With HAZARD_PERF_EN, perf_stall_cnt reads 0 after reset and 3 after three stall cycles.
